fht_but_pipe: RTL and testbench

Parametrised radix-2 Hartley butterfly with a valid-qualified pipeline, the successor to the fixed two-cycle butterfly in the FHT datapath. Per valid sample it computes Y0 = X0 + M and Y1 = X0 − M, where M = X1·cos + X2·sin, or M = X1 in twiddle-bypass mode.
- Run-time selectable: divide-by-2 scaling with rounding.
- Compile-time selectable: extra multiplier pipeline register.
- Saturation on every narrowing step, with a sticky overflow flag.
- Sits between the FHT memory read mux and the write-back path, one instance per butterfly lane.

---
 rtl/fht_but_pipe_if.sv | 30 +++
 rtl/fht_but_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_fht_but_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_but_pipe_if.sv
// Sample/result bundle for one butterfly lane of the FHT datapath.
// The master side drives operands and twiddles; the slave side returns results.
interface fht_but_pipe_if #(
    parameter int D_BIT = 17,
    parameter int W_BIT = 12
);
    logic                    iVALID;
    logic                    iSEL;
    logic                    iSCALE;
    logic                    iCLR_OVF;
    logic signed [D_BIT-1:0] iX_0;
    logic signed [D_BIT-1:0] iX_1;
    logic signed [D_BIT-1:0] iX_2;
    logic signed [W_BIT-1:0] iSIN;
    logic signed [W_BIT-1:0] iCOS;
    logic                    oVALID;
    logic signed [D_BIT-1:0] oY_0;
    logic signed [D_BIT-1:0] oY_1;
    logic                    oOVF;

    modport master (
        output iVALID, iSEL, iSCALE, iCLR_OVF, iX_0, iX_1, iX_2, iSIN, iCOS,
        input  oVALID, oY_0, oY_1, oOVF
    );

    modport slave (
        input  iVALID, iSEL, iSCALE, iCLR_OVF, iX_0, iX_1, iX_2, iSIN, iCOS,
        output oVALID, oY_0, oY_1, oOVF
    );
endinterface

// File: rtl/fht_but_pipe.sv
// Radix-2 Hartley butterfly: Y0 = X0 + M, Y1 = X0 - M with M = X1*cos + X2*sin
// (or M = X1 in bypass). Valid-qualified pipeline, latency 2 + MUL_PIPE, no stall.
// Every narrowing step saturates; any clip on a valid sample sets the sticky oOVF.
module fht_but_pipe #(
    parameter int D_BIT    = 17,
    parameter int W_BIT    = 12,
    parameter int MUL_PIPE = 0
) (
    input logic          iCLK,
    input logic          iRESET,
    fht_but_pipe_if.slave bus
);

    localparam int PW = D_BIT + W_BIT + 1;   // full product-sum width
    localparam int SH = W_BIT - 2;           // unity twiddle = 2^SH
    localparam int AW = D_BIT + 2;           // add/sub width incl. rounding headroom

    localparam logic signed [PW-1:0] C_RND   = PW'(1) << (SH - 1);
    localparam logic signed [PW-1:0] C_MAX_M = {{(PW-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
    localparam logic signed [PW-1:0] C_MIN_M = {{(PW-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};
    localparam logic signed [AW-1:0] C_MAX_Y = {{(AW-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
    localparam logic signed [AW-1:0] C_MIN_Y = {{(AW-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};

    // ---------------- stage 1: twiddle multiply, round, saturate ----------------
    logic signed [PW-1:0]    w_x1_e;
    logic signed [PW-1:0]    w_x2_e;
    logic signed [PW-1:0]    w_cos_e;
    logic signed [PW-1:0]    w_sin_e;
    logic signed [PW-1:0]    w_p;
    logic signed [PW-1:0]    w_m_wide;
    logic signed [D_BIT-1:0] w_m;
    logic                    w_sat_m;

    // M before and after clipping to the data range
    always_comb begin
        w_x1_e   = PW'(bus.iX_1);
        w_x2_e   = PW'(bus.iX_2);
        w_cos_e  = PW'(bus.iCOS);
        w_sin_e  = PW'(bus.iSIN);
        w_p      = w_x1_e * w_cos_e + w_x2_e * w_sin_e;
        w_m_wide = bus.iSEL ? w_x1_e : ((w_p + C_RND) >>> SH);
        w_sat_m  = 1'b0;
        w_m      = w_m_wide[D_BIT-1:0];
        if (w_m_wide > C_MAX_M) begin
            w_sat_m = 1'b1;
            w_m     = C_MAX_M[D_BIT-1:0];
        end else if (w_m_wide < C_MIN_M) begin
            w_sat_m = 1'b1;
            w_m     = C_MIN_M[D_BIT-1:0];
        end
    end

    logic                    r_v1;
    logic signed [D_BIT-1:0] r_m1;
    logic signed [D_BIT-1:0] r_x0_1;
    logic                    r_scale_1;
    logic                    r_satm_1;

    // stage 1 register; data side loads only for valid samples
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_v1      <= 1'b0;
            r_m1      <= '0;
            r_x0_1    <= '0;
            r_scale_1 <= 1'b0;
            r_satm_1  <= 1'b0;
        end else begin
            r_v1 <= bus.iVALID;
            if (bus.iVALID) begin
                r_m1      <= w_m;
                r_x0_1    <= bus.iX_0;
                r_scale_1 <= bus.iSCALE;
                r_satm_1  <= w_sat_m;
            end
        end
    end

    // ---------------- optional stage 1b: extra multiplier register ----------------
    logic                    w_v_s2;
    logic signed [D_BIT-1:0] w_m_s2;
    logic signed [D_BIT-1:0] w_x0_s2;
    logic                    w_scale_s2;
    logic                    w_satm_s2;

    if (MUL_PIPE != 0) begin : g_mul_pipe
        logic                    r_v1b;
        logic signed [D_BIT-1:0] r_m1b;
        logic signed [D_BIT-1:0] r_x0_1b;
        logic                    r_scale_1b;
        logic                    r_satm_1b;

        // retime stage 1 results by one cycle, same load-on-valid rule
        always_ff @(posedge iCLK or negedge iRESET) begin
            if (!iRESET) begin
                r_v1b      <= 1'b0;
                r_m1b      <= '0;
                r_x0_1b    <= '0;
                r_scale_1b <= 1'b0;
                r_satm_1b  <= 1'b0;
            end else begin
                r_v1b <= r_v1;
                if (r_v1) begin
                    r_m1b      <= r_m1;
                    r_x0_1b    <= r_x0_1;
                    r_scale_1b <= r_scale_1;
                    r_satm_1b  <= r_satm_1;
                end
            end
        end

        assign w_v_s2     = r_v1b;
        assign w_m_s2     = r_m1b;
        assign w_x0_s2    = r_x0_1b;
        assign w_scale_s2 = r_scale_1b;
        assign w_satm_s2  = r_satm_1b;
    end else begin : g_no_pipe
        assign w_v_s2     = r_v1;
        assign w_m_s2     = r_m1;
        assign w_x0_s2    = r_x0_1;
        assign w_scale_s2 = r_scale_1;
        assign w_satm_s2  = r_satm_1;
    end

    // ---------------- stage 2: add/sub, scale or saturate ----------------
    logic signed [AW-1:0]    w_x0_e;
    logic signed [AW-1:0]    w_m_e;
    logic signed [AW-1:0]    w_sum;
    logic signed [AW-1:0]    w_dif;
    logic signed [AW-1:0]    w_sum_p1;
    logic signed [AW-1:0]    w_dif_p1;
    logic signed [D_BIT-1:0] w_y0;
    logic signed [D_BIT-1:0] w_y1;
    logic                    w_sat_y;
    logic                    w_unused;

    // halving with round-half-up always fits; full scale clips each output
    always_comb begin
        w_x0_e   = AW'(w_x0_s2);
        w_m_e    = AW'(w_m_s2);
        w_sum    = w_x0_e + w_m_e;
        w_dif    = w_x0_e - w_m_e;
        w_sum_p1 = w_sum + AW'(1);
        w_dif_p1 = w_dif + AW'(1);
        w_sat_y  = 1'b0;
        w_y0     = w_sum[D_BIT-1:0];
        w_y1     = w_dif[D_BIT-1:0];
        if (w_scale_s2) begin
            w_y0 = w_sum_p1[D_BIT:1];
            w_y1 = w_dif_p1[D_BIT:1];
        end else begin
            if (w_sum > C_MAX_Y) begin
                w_y0    = C_MAX_Y[D_BIT-1:0];
                w_sat_y = 1'b1;
            end else if (w_sum < C_MIN_Y) begin
                w_y0    = C_MIN_Y[D_BIT-1:0];
                w_sat_y = 1'b1;
            end
            if (w_dif > C_MAX_Y) begin
                w_y1    = C_MAX_Y[D_BIT-1:0];
                w_sat_y = 1'b1;
            end else if (w_dif < C_MIN_Y) begin
                w_y1    = C_MIN_Y[D_BIT-1:0];
                w_sat_y = 1'b1;
            end
        end
    end

    assign w_unused = ^{w_sum_p1[AW-1], w_sum_p1[0], w_dif_p1[AW-1], w_dif_p1[0]};

    logic                    r_vout;
    logic signed [D_BIT-1:0] r_y0;
    logic signed [D_BIT-1:0] r_y1;
    logic                    r_ovf;

    // output register and sticky overflow (set beats clear)
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_vout <= 1'b0;
            r_y0   <= '0;
            r_y1   <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_vout <= w_v_s2;
            if (w_v_s2) begin
                r_y0 <= w_y0;
                r_y1 <= w_y1;
            end
            if (w_v_s2 && (w_satm_s2 || w_sat_y)) begin
                r_ovf <= 1'b1;
            end else if (bus.iCLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.oVALID = r_vout;
    assign bus.oY_0   = r_y0;
    assign bus.oY_1   = r_y1;
    assign bus.oOVF   = r_ovf;

endmodule

// File: tb/tb_fht_but_pipe.sv
// Bench for fht_but_pipe: one instance per MUL_PIPE setting fed the same stream,
// compared every cycle against an arithmetic reference model.
module tb_fht_but_pipe;
    localparam int D_BIT = 17;
    localparam int W_BIT = 12;

    logic iCLK   = 1'b0;
    logic iRESET = 1'b0;
    always #5 iCLK = ~iCLK;

    fht_but_pipe_if #(.D_BIT(D_BIT), .W_BIT(W_BIT)) bus0 ();
    fht_but_pipe_if #(.D_BIT(D_BIT), .W_BIT(W_BIT)) bus1 ();

    assign bus1.iVALID   = bus0.iVALID;
    assign bus1.iSEL     = bus0.iSEL;
    assign bus1.iSCALE   = bus0.iSCALE;
    assign bus1.iCLR_OVF = bus0.iCLR_OVF;
    assign bus1.iX_0     = bus0.iX_0;
    assign bus1.iX_1     = bus0.iX_1;
    assign bus1.iX_2     = bus0.iX_2;
    assign bus1.iSIN     = bus0.iSIN;
    assign bus1.iCOS     = bus0.iCOS;

    fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .MUL_PIPE(0)) u_dut0 (
        .iCLK(iCLK), .iRESET(iRESET), .bus(bus0)
    );
    fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .MUL_PIPE(1)) u_dut1 (
        .iCLK(iCLK), .iRESET(iRESET), .bus(bus1)
    );

    typedef struct {
        bit v;
        int x0, x1, x2, c, s;
        bit sel, scale, clr;
    } smp_t;

    smp_t cur;
    smp_t hist[$];
    int   ey0[2], ey1[2];
    bit   ev[2], eovf[2];
    int   n_chk = 0;
    int   n_bad = 0;
    int   seen0[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, output bit hit);
        int hi = (1 << (D_BIT - 1)) - 1;
        int lo = -(1 << (D_BIT - 1));
        hit = 1'b0;
        if (v > hi) begin hit = 1'b1; return hi; end
        if (v < lo) begin hit = 1'b1; return lo; end
        return v;
    endfunction

    // butterfly evaluated with plain integer/real arithmetic
    function automatic void ref_calc(input smp_t s, output int y0, output int y1, output bit sat);
        int  m, p, sm, df;
        bit  h;
        real unity, half;
        unity = real'(1 << (W_BIT - 2));
        half  = unity / 2.0;
        sat   = 1'b0;
        if (s.sel) m = s.x1;
        else begin
            p = s.x1 * s.c + s.x2 * s.s;
            m = $rtoi($floor((real'(p) + half) / unity));
        end
        m = clamp(m, h); sat |= h;
        sm = s.x0 + m;
        df = s.x0 - m;
        if (s.scale) begin
            y0 = $rtoi($floor((real'(sm) + 1.0) / 2.0));
            y1 = $rtoi($floor((real'(df) + 1.0) / 2.0));
        end else begin
            y0 = clamp(sm, h); sat |= h;
            y1 = clamp(df, h); sat |= h;
        end
    endfunction

    task automatic model_edge();
        for (int j = 0; j < 2; j++) begin
            int idx;
            int y0, y1;
            bit sat;
            bit set;
            idx   = hist.size() - (2 + j);
            ev[j] = 1'b0;
            set   = 1'b0;
            if (idx >= 0 && hist[idx].v) begin
                ref_calc(hist[idx], y0, y1, sat);
                ev[j]  = 1'b1;
                ey0[j] = y0;
                ey1[j] = y1;
                set    = sat;
            end
            if (set) eovf[j] = 1'b1;
            else if (hist[hist.size()-1].clr) eovf[j] = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".d0.v"},   int'(bus0.oVALID), int'(ev[0]));
        chk({tag, ".d0.y0"},  int'(bus0.oY_0),   ey0[0]);
        chk({tag, ".d0.y1"},  int'(bus0.oY_1),   ey1[0]);
        chk({tag, ".d0.ovf"}, int'(bus0.oOVF),   int'(eovf[0]));
        chk({tag, ".d1.v"},   int'(bus1.oVALID), int'(ev[1]));
        chk({tag, ".d1.y0"},  int'(bus1.oY_0),   ey1[1] == ey1[1] ? ey0[1] : 0);
        chk({tag, ".d1.y1"},  int'(bus1.oY_1),   ey1[1]);
        chk({tag, ".d1.ovf"}, int'(bus1.oOVF),   int'(eovf[1]));
    endtask

    task automatic drive();
        bus0.iVALID   = cur.v;
        bus0.iSEL     = cur.sel;
        bus0.iSCALE   = cur.scale;
        bus0.iCLR_OVF = cur.clr;
        bus0.iX_0     = D_BIT'(cur.x0);
        bus0.iX_1     = D_BIT'(cur.x1);
        bus0.iX_2     = D_BIT'(cur.x2);
        bus0.iCOS     = W_BIT'(cur.c);
        bus0.iSIN     = W_BIT'(cur.s);
    endtask

    task automatic set_s(input bit v, input int x0, input int x1, input int x2,
                         input int c, input int s, input bit sel, input bit scale, input bit clr);
        cur.v = v; cur.x0 = x0; cur.x1 = x1; cur.x2 = x2; cur.c = c; cur.s = s;
        cur.sel = sel; cur.scale = scale; cur.clr = clr;
    endtask

    task automatic step(input string tag);
        drive();
        @(posedge iCLK);
        hist.push_back(cur);
        model_edge();
        #1;
        check_outs(tag);
        if (bus0.oVALID) seen0.push_back(int'(bus0.oY_0));
    endtask

    task automatic idle(input int n, input string tag);
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step(tag);
    endtask

    function automatic int rnd_d();
        return int'($urandom_range(0, (1 << D_BIT) - 1)) - (1 << (D_BIT - 1));
    endfunction

    function automatic int rnd_w();
        return int'($urandom_range(0, (1 << W_BIT) - 1)) - (1 << (W_BIT - 1));
    endfunction

    initial begin
        int exp_seq[6];
        int pat[9];
        exp_seq = '{1, 2, 4, 5, 6, 9};
        pat     = '{1, 1, 0, 1, 1, 1, 0, 0, 1};
        for (int j = 0; j < 2; j++) begin
            ey0[j] = 0; ey1[j] = 0; ev[j] = 0; eovf[j] = 0;
        end
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive();
        repeat (2) @(posedge iCLK);
        #1;
        check_outs("rst");
        @(negedge iCLK);
        iRESET = 1'b1;

        // pure rotation, scaled
        set_s(1, 100, 200, 0, 1024, 0, 0, 1, 0);
        step("t1a");
        chk("t1.lat1.d0.v", int'(bus0.oVALID), 0);
        idle(1, "t1b");
        chk("t1.d0.v",  int'(bus0.oVALID), 1);
        chk("t1.d0.y0", int'(bus0.oY_0), 150);
        chk("t1.d0.y1", int'(bus0.oY_1), -50);
        chk("t1.d0.ovf", int'(bus0.oOVF), 0);
        idle(2, "t1c");

        // unscaled, both latencies
        set_s(1, 100, 200, 0, 1024, 0, 0, 0, 0);
        step("t2a");
        idle(1, "t2b");
        chk("t2.d0.y0", int'(bus0.oY_0), 300);
        chk("t2.d0.y1", int'(bus0.oY_1), -100);
        chk("t2.lat2.d1.v", int'(bus1.oVALID), 0);
        idle(1, "t2c");
        chk("t2.d1.v",  int'(bus1.oVALID), 1);
        chk("t2.d1.y0", int'(bus1.oY_0), 300);
        chk("t2.d1.y1", int'(bus1.oY_1), -100);
        idle(1, "t2d");

        // multiply rounding, half up
        set_s(1, 0, 3, 0, 512, 0, 0, 0, 0);
        step("t3a");
        set_s(1, 0, -3, 0, 512, 0, 0, 0, 0);
        step("t3b");
        chk("t3.pos.y0", int'(bus0.oY_0), 2);
        chk("t3.pos.y1", int'(bus0.oY_1), -2);
        idle(1, "t3c");
        chk("t3.neg.y0", int'(bus0.oY_0), -1);
        chk("t3.neg.y1", int'(bus0.oY_1), 1);
        idle(2, "t3d");

        // saturation and sticky flag
        set_s(1, 65535, 65535, 0, 0, 0, 1, 0, 0);
        step("t4a");
        idle(1, "t4b");
        chk("t4.sat.y0", int'(bus0.oY_0), 65535);
        chk("t4.sat.y1", int'(bus0.oY_1), 0);
        chk("t4.sat.ovf", int'(bus0.oOVF), 1);
        for (int i = 0; i < 10; i++) begin
            set_s(1, i * 7, i, 0, 0, 0, 1, 0, 0);
            step("t4clean");
        end
        idle(2, "t4e");
        chk("t4.sticky", int'(bus0.oOVF), 1);
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("t4clr");
        chk("t4.cleared", int'(bus0.oOVF), 0);
        idle(1, "t4f");
        set_s(1, -65536, 65535, 0, 0, 0, 1, 0, 0);
        step("t4g");
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("t4h");
        chk("t4.setwins", int'(bus0.oOVF), 1);
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) step("t4i");
        idle(1, "t4j");

        // streaming with gaps
        seen0.delete();
        for (int i = 0; i < 9; i++) begin
            set_s(pat[i] != 0, i + 1, 0, 0, 0, 0, 1, 0, 0);
            step("t5");
        end
        idle(3, "t5tail");
        chk("t5.count", seen0.size(), 6);
        for (int i = 0; i < 6 && i < seen0.size(); i++)
            chk($sformatf("t5.seq%0d", i), seen0[i], exp_seq[i]);

        // reset with samples in flight
        for (int i = 0; i < 3; i++) begin
            set_s(1, 65535, 65535, 0, 0, 0, 1, 0, 0);
            step("t6fill");
        end
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive();
        #2;
        iRESET = 1'b0;
        #1;
        hist.delete();
        for (int j = 0; j < 2; j++) begin
            ey0[j] = 0; ey1[j] = 0; ev[j] = 0; eovf[j] = 0;
        end
        check_outs("t6rst");
        @(posedge iCLK);
        @(negedge iCLK);
        iRESET = 1'b1;
        idle(3, "t6flush");
        set_s(1, 1234, 222, 0, 0, 0, 1, 0, 0);
        step("t6new");
        idle(1, "t6newb");
        chk("t6.new.d0.v", int'(bus0.oVALID), 1);
        chk("t6.new.d0.y0", int'(bus0.oY_0), 1456);
        idle(3, "t6tail");

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            int c, s;
            if ($urandom_range(0, 3) == 0) begin c = 1024; s = 0; end
            else begin c = rnd_w(); s = rnd_w(); end
            set_s($urandom_range(0, 3) != 0, rnd_d(), rnd_d(), rnd_d(), c, s,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0);
            step("rnd");
        end
        idle(4, "end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
